// File: rtl/vec_reg_file.sv
// Vector register file: NREGS x (LANES*LANE_W) bits, two combinational read ports,
// one masked write port, built-in clear sequencer. Define VRF_BYPASS_EN for write-to-read forwarding.
module vec_reg_file #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8,
  parameter int NREGS  = 12,
  parameter int AW     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [LANES*LANE_W-1:0] wd,
  input  logic [LANES-1:0]        wmask,
  input  logic [AW-1:0]           ra1,
  input  logic [AW-1:0]           ra2,
  output logic [LANES*LANE_W-1:0] rd1,
  output logic [LANES*LANE_W-1:0] rd2
);

  localparam int DW = LANES * LANE_W;
  localparam logic [AW:0] W_NREGS = (AW + 1)'(NREGS);
  localparam logic [AW-1:0] W_LAST = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic          r_busy;
  logic [DW-1:0] r_rf [NREGS];
  logic          w_we_ok;
  logic [AW-1:0] w_ra [2];
  logic [DW-1:0] w_rd [2];

  assign w_we_ok = we && (r_state == ST_IDLE) && ({1'b0, wa} < W_NREGS);

  // Clear sequencer next-state: walk every register once, then idle until asked again.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        if (r_ptr == W_LAST) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Sequencer state, pointer and registered busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt == ST_CLEAR);
    end
  end

  // Storage: zeroed one row per cycle while clearing, otherwise lane-masked writes.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_rf[r_ptr] <= '0;
    end else if (w_we_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          r_rf[wa][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;

  // Read ports: zero while clearing or out of range, optional same-cycle forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = r_rf[w_ra[p]];
`ifdef VRF_BYPASS_EN
      if (w_we_ok && (wa == w_ra[p])) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) begin
            w_rd[p][i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
          end else begin
            w_rd[p][i*LANE_W +: LANE_W] = r_rf[w_ra[p]][i*LANE_W +: LANE_W];
          end
        end
      end else begin
        w_rd[p] = r_rf[w_ra[p]];
      end
`endif
      if (r_busy || ({1'b0, w_ra[p]} >= W_NREGS)) begin
        w_rd[p] = '0;
      end else begin
        w_rd[p] = w_rd[p];
      end
    end
  end

  assign busy = r_busy;
  assign rd1  = w_rd[0];
  assign rd2  = w_rd[1];

endmodule
